// File: rtl/csr_arb_pkg.sv
// Shared types and constants for the two-master CSR arbiter.
package csr_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 32;

   // Read data returned to a master whose read never got a CSR response
   localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2,
      RESP    = 2'd3
   } arb_state_e;

endpackage

// File: rtl/csr_avmm_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters, the arbiter and csr_ctrl.
// The slave modport is the arbiter's view; master is the environment's view.
interface csr_avmm_arbiter_if
   import csr_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic [ADDR_W-1:0] m0_address;
   logic              m0_read;
   logic              m0_write;
   logic [DATA_W-1:0] m0_writedata;
   logic              m0_waitrequest;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_readdatavalid;

   logic [ADDR_W-1:0] m1_address;
   logic              m1_read;
   logic              m1_write;
   logic [DATA_W-1:0] m1_writedata;
   logic              m1_waitrequest;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_readdatavalid;

   logic [ADDR_W-1:0] csr_wr_rd_addr;
   logic              csr_wr_en;
   logic              csr_rd_en;
   logic [DATA_W-1:0] csr_wr_data;
   logic [DATA_W-1:0] csr_rd_datain;
   logic              csr_rd_dvalid;

   modport slave (
      input  m0_address, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_read, m1_write, m1_writedata,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output csr_wr_rd_addr, csr_wr_en, csr_rd_en, csr_wr_data,
      input  csr_rd_datain, csr_rd_dvalid
   );

   modport master (
      output m0_address, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_read, m1_write, m1_writedata,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  csr_wr_rd_addr, csr_wr_en, csr_rd_en, csr_wr_data,
      output csr_rd_datain, csr_rd_dvalid
   );

endinterface

// File: rtl/csr_avmm_arbiter.sv
// Round-robin arbiter sharing the CSR register port between two Avalon-MM
// masters, one transaction in flight at a time. All outputs are registered.
// Optional feature: define CSR_ARB_TIMEOUT_EN to bound the read-response wait
// and raise a sticky arb_timeout_err.
module csr_avmm_arbiter
   import csr_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   csr_avmm_arbiter_if.slave  bus,
   output logic               arb_timeout_err
);

   // A zero timeout would make the response counter compare meaningless
   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("csr_avmm_arbiter: TIMEOUT must be nonzero");
   end

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;      // master that owns the port
   logic              last_q, last_d;        // master granted most recently
   logic              is_wr_q, is_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wr_en_q, wr_en_d;
   logic              rd_en_q, rd_en_d;
   logic              wait0_q, wait0_d;
   logic              wait1_q, wait1_d;
   logic              rdv0_q, rdv0_d;
   logic              rdv1_q, rdv1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic              m0_req, m1_req;
   logic              gnt;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;

`ifdef CSR_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   assign m0_req = bus.m0_read | bus.m0_write;
   assign m1_req = bus.m1_read | bus.m1_write;

   // Next-state, capture and registered-output decode
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      wait0_d   = 1'b1;
      wait1_d   = 1'b1;
      rdv0_d    = 1'b0;
      rdv1_d    = 1'b0;
      rdata0_d  = '0;
      rdata1_d  = '0;
      gnt       = 1'b0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
`ifdef CSR_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               // On contention the master not granted last wins
               gnt      = (m0_req && m1_req) ? ~last_q : m1_req;
               owner_d  = gnt;
               last_d   = gnt;
               addr_d   = gnt ? bus.m1_address   : bus.m0_address;
               wdata_d  = gnt ? bus.m1_writedata : bus.m0_writedata;
               // read and write together resolve to a write
               is_wr_d  = gnt ? bus.m1_write : bus.m0_write;
               wr_en_d  = is_wr_d;
               rd_en_d  = ~is_wr_d;
               wait0_d  = gnt;
               wait1_d  = ~gnt;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            state_d = is_wr_q ? IDLE : RD_WAIT;
`ifdef CSR_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         RD_WAIT: begin
            if (bus.csr_rd_dvalid) begin
               rsp_valid = 1'b1;
               rsp_data  = bus.csr_rd_datain;
            end
`ifdef CSR_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rsp_valid = 1'b1;
               rsp_data  = DATA_W'(DEAD_BEEF);
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
            if (rsp_valid) begin
               rdv0_d   = ~owner_q;
               rdv1_d   = owner_q;
               rdata0_d = owner_q ? '0 : rsp_data;
               rdata1_d = owner_q ? rsp_data : '0;
               state_d  = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         is_wr_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         wait0_q  <= 1'b1;
         wait1_q  <= 1'b1;
         rdv0_q   <= 1'b0;
         rdv1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
`ifdef CSR_ARB_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         is_wr_q  <= is_wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_en_q  <= wr_en_d;
         rd_en_q  <= rd_en_d;
         wait0_q  <= wait0_d;
         wait1_q  <= wait1_d;
         rdv0_q   <= rdv0_d;
         rdv1_q   <= rdv1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
`ifdef CSR_ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   assign bus.csr_wr_rd_addr   = addr_q;
   assign bus.csr_wr_data      = wdata_q;
   assign bus.csr_wr_en        = wr_en_q;
   assign bus.csr_rd_en        = rd_en_q;
   assign bus.m0_waitrequest   = wait0_q;
   assign bus.m1_waitrequest   = wait1_q;
   assign bus.m0_readdatavalid = rdv0_q;
   assign bus.m1_readdatavalid = rdv1_q;
   assign bus.m0_readdata      = rdata0_q;
   assign bus.m1_readdata      = rdata1_q;

`ifdef CSR_ARB_TIMEOUT_EN
   assign arb_timeout_err = err_q;
`else
   assign arb_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_csr_avmm_arbiter.sv
// Self-checking bench for csr_avmm_arbiter: transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_csr_avmm_arbiter;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TIMEOUT = 255;

   typedef logic [31:0] w32_q_t[$];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic arb_timeout_err;

   csr_avmm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   csr_avmm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .arb_timeout_err (arb_timeout_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, req);
      end
   endtask

   function automatic logic [31:0] qget(input w32_q_t q, input int i);
      if (i < q.size()) return q[i];
      return 32'hFFFF_FFFF;
   endfunction

   // ---------------- reference model ----------------
   bit          m_last, m_owner, m_pend, m_err;
   int          m_free_at, m_rd_from;
   logic        e_w0, e_w1, e_wr, e_rd, e_rdv0, e_rdv1;
   logic [31:0] e_rd0, e_rd1, e_addr, e_wdata;

   task automatic mdl_quiet();
      e_w0 = 1'b1; e_w1 = 1'b1; e_wr = 1'b0; e_rd = 1'b0;
      e_rdv0 = 1'b0; e_rdv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
   endtask

   task automatic mdl_reset();
      m_last = 1'b1; m_owner = 1'b0; m_pend = 1'b0; m_err = 1'b0;
      m_free_at = 0; m_rd_from = 0;
      e_addr = '0; e_wdata = '0;
      mdl_quiet();
   endtask

   task automatic mdl_respond(input logic [31:0] d);
      if (m_owner) begin e_rdv1 = 1'b1; e_rd1 = d; end
      else         begin e_rdv0 = 1'b1; e_rd0 = d; end
      m_pend    = 1'b0;
      m_free_at = cyc + 2;
   endtask

   // Given the inputs visible in cycle cyc, set the expected outputs of cyc+1
   task automatic mdl_step();
      bit r0, r1, g, w;
      r0 = bus.m0_read | bus.m0_write;
      r1 = bus.m1_read | bus.m1_write;
      mdl_quiet();
      if (!m_pend && cyc >= m_free_at && (r0 || r1)) begin
         g       = (r0 && r1) ? !m_last : r1;
         m_last  = g;
         m_owner = g;
         w       = g ? bus.m1_write : bus.m0_write;
         e_addr  = g ? 32'(bus.m1_address) : 32'(bus.m0_address);
         e_wdata = g ? bus.m1_writedata : bus.m0_writedata;
         if (g) e_w1 = 1'b0; else e_w0 = 1'b0;
         if (w) begin
            e_wr      = 1'b1;
            m_free_at = cyc + 2;
         end else begin
            e_rd      = 1'b1;
            m_pend    = 1'b1;
            m_rd_from = cyc + 2;
         end
      end else if (m_pend && cyc >= m_rd_from) begin
         if (bus.csr_rd_dvalid) mdl_respond(bus.csr_rd_datain);
`ifdef CSR_ARB_TIMEOUT_EN
         else if (cyc - m_rd_from + 1 == int'(TIMEOUT)) begin
            mdl_respond(32'hDEAD_BEEF);
            m_err = 1'b1;
         end
`endif
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst_n) mdl_reset();
      chk("m0_waitrequest",   32'(bus.m0_waitrequest),   32'(e_w0));
      chk("m1_waitrequest",   32'(bus.m1_waitrequest),   32'(e_w1));
      chk("csr_wr_en",        32'(bus.csr_wr_en),        32'(e_wr));
      chk("csr_rd_en",        32'(bus.csr_rd_en),        32'(e_rd));
      chk("csr_wr_rd_addr",   32'(bus.csr_wr_rd_addr),   e_addr);
      chk("csr_wr_data",      bus.csr_wr_data,           e_wdata);
      chk("m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'(e_rdv0));
      chk("m1_readdatavalid", 32'(bus.m1_readdatavalid), 32'(e_rdv1));
      chk("m0_readdata",      bus.m0_readdata,           e_rd0);
      chk("m1_readdata",      bus.m1_readdata,           e_rd1);
      chk("arb_timeout_err",  32'(arb_timeout_err),      32'(m_err));
      if (rst_n) mdl_step();
   end

   // ---------------- event logs for directed checks ----------------
   w32_q_t wr_addr_log, wr_data_log, wr_cyc_log, rd_cyc_log;
   w32_q_t rdv0_cyc, rdv0_dat, rdv1_cyc, rdv1_dat, w0_low_log, w1_low_log;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.csr_wr_en) begin
            wr_addr_log.push_back(32'(bus.csr_wr_rd_addr));
            wr_data_log.push_back(bus.csr_wr_data);
            wr_cyc_log.push_back(32'(cyc));
         end
         if (bus.csr_rd_en) rd_cyc_log.push_back(32'(cyc));
         if (bus.m0_readdatavalid) begin
            rdv0_cyc.push_back(32'(cyc));
            rdv0_dat.push_back(bus.m0_readdata);
         end
         if (bus.m1_readdatavalid) begin
            rdv1_cyc.push_back(32'(cyc));
            rdv1_dat.push_back(bus.m1_readdata);
         end
         if (!bus.m0_waitrequest) w0_low_log.push_back(32'(cyc));
         if (!bus.m1_waitrequest) w1_low_log.push_back(32'(cyc));
      end
   end

   task automatic clear_logs();
      wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete(); rd_cyc_log.delete();
      rdv0_cyc.delete(); rdv0_dat.delete(); rdv1_cyc.delete(); rdv1_dat.delete();
      w0_low_log.delete(); w1_low_log.delete();
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input bit m, input bit rd, input bit wr,
                          input logic [15:0] a, input logic [31:0] d);
      if (m) begin
         bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a; bus.m1_writedata = d;
      end else begin
         bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a; bus.m0_writedata = d;
      end
   endtask

   // Hold a request until accepted (waitrequest low), then drop it
   task automatic mreq(input bit m, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [31:0] d, output int rc);
      bit acc;
      acc = 1'b0;
      set_req(m, rd, wr, a, d);
      rc = cyc;
      for (int i = 0; i < 1000 && !acc; i++) begin
         @(negedge clk);
         acc = m ? !bus.m1_waitrequest : !bus.m0_waitrequest;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout m%0d got=waitrequest_high expected=accept", m);
      end
      tick();
      set_req(m, 1'b0, 1'b0, 16'h0, 32'h0);
   endtask

   task automatic pulse_dvalid(input logic [31:0] d);
      bus.csr_rd_datain = d;
      bus.csr_rd_dvalid = 1'b1;
      tick();
      bus.csr_rd_dvalid = 1'b0;
      bus.csr_rd_datain = '0;
   endtask

   // Answer the next csr_rd_en with dvalid n cycles later
   task automatic respond(input int n, input logic [31:0] d);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge clk);
         seen = bus.csr_rd_en;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL rd_en_timeout got=no_csr_rd_en expected=csr_rd_en");
      end
      repeat (n) tick();
      pulse_dvalid(d);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int rc, rc2;
      set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
      bus.csr_rd_dvalid = 1'b0;
      bus.csr_rd_datain = '0;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset values
      chk("rst_m0_wait", 32'(bus.m0_waitrequest), 32'd1);
      chk("rst_m1_wait", 32'(bus.m1_waitrequest), 32'd1);
      chk("rst_addr",    32'(bus.csr_wr_rd_addr), 32'd0);
      chk("rst_err",     32'(arb_timeout_err),    32'd0);

      // Single write from m0
      clear_logs();
      mreq(1'b0, 1'b0, 1'b1, 16'h0010, 32'h0000_0003, rc);
      tick();
      chk("t1_wr_count",  32'(wr_addr_log.size()), 32'd1);
      chk("t1_wr_addr",   qget(wr_addr_log, 0), 32'h0000_0010);
      chk("t1_wr_data",   qget(wr_data_log, 0), 32'h0000_0003);
      chk("t1_wr_lat",    qget(wr_cyc_log, 0) - 32'(rc), 32'd1);
      chk("t1_w0_lowcnt", 32'(w0_low_log.size()), 32'd1);
      chk("t1_w0_lowcyc", qget(w0_low_log, 0) - 32'(rc), 32'd1);

      // m1 read answered 3 cycles after csr_rd_en
      clear_logs();
      fork
         mreq(1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, rc);
         respond(3, 32'hA5A5_5A5A);
      join
      repeat (3) tick();
      chk("t2_rd_lat",    qget(rd_cyc_log, 0) - 32'(rc), 32'd1);
      chk("t2_rdv1_cnt",  32'(rdv1_cyc.size()), 32'd1);
      chk("t2_rdv1_lat",  qget(rdv1_cyc, 0) - qget(rd_cyc_log, 0), 32'd4);
      chk("t2_rdv1_data", qget(rdv1_dat, 0), 32'hA5A5_5A5A);
      chk("t2_rdv0_cnt",  32'(rdv0_cyc.size()), 32'd0);

      // Both masters write together from reset: m0, m1, m0, m1
      do_reset();
      clear_logs();
      for (int i = 0; i < 2; i++) begin
         fork
            mreq(1'b0, 1'b0, 1'b1, 16'(16'h0100 + i), 32'(32'h10 + i), rc);
            mreq(1'b1, 1'b0, 1'b1, 16'(16'h0200 + i), 32'(32'h20 + i), rc2);
         join
      end
      tick();
      chk("t3_wr_count", 32'(wr_addr_log.size()), 32'd4);
      chk("t3_grant0",   qget(wr_addr_log, 0), 32'h0100);
      chk("t3_grant1",   qget(wr_addr_log, 1), 32'h0200);
      chk("t3_grant2",   qget(wr_addr_log, 2), 32'h0101);
      chk("t3_grant3",   qget(wr_addr_log, 3), 32'h0201);
      chk("t3_rate",     qget(wr_cyc_log, 1) - qget(wr_cyc_log, 0), 32'd2);

      // m1 write waits behind an outstanding m0 read
      clear_logs();
      fork
         mreq(1'b0, 1'b1, 1'b0, 16'h0044, 32'h0, rc);
         respond(4, 32'h0BAD_F00D);
         begin
            tick();
            tick();
            mreq(1'b1, 1'b0, 1'b1, 16'h0048, 32'h0000_0099, rc2);
         end
      join
      repeat (2) tick();
      chk("t4_rdv0_data", qget(rdv0_dat, 0), 32'h0BAD_F00D);
      chk("t4_wr_addr",   qget(wr_addr_log, 0), 32'h0048);
      chk("t4_wr_after",  qget(wr_cyc_log, 0) - qget(rdv0_cyc, 0), 32'd2);
      chk("t4_w1_lowcyc", qget(w1_low_log, 0), qget(wr_cyc_log, 0));

      // read and write together resolve to a write
      clear_logs();
      mreq(1'b1, 1'b1, 1'b1, 16'h0030, 32'h0000_0077, rc);
      tick();
      chk("t7_wr_count", 32'(wr_addr_log.size()), 32'd1);
      chk("t7_rd_count", 32'(rd_cyc_log.size()), 32'd0);
      chk("t7_wr_data",  qget(wr_data_log, 0), 32'h0000_0077);

      // After an m0-only grant, contention goes to m1
      clear_logs();
      mreq(1'b0, 1'b0, 1'b1, 16'h0040, 32'h1, rc);
      fork
         mreq(1'b0, 1'b0, 1'b1, 16'h0050, 32'h2, rc);
         mreq(1'b1, 1'b0, 1'b1, 16'h0051, 32'h3, rc2);
      join
      tick();
      chk("t8_order0", qget(wr_addr_log, 0), 32'h0040);
      chk("t8_order1", qget(wr_addr_log, 1), 32'h0051);
      chk("t8_order2", qget(wr_addr_log, 2), 32'h0050);

      // Unanswered read
      clear_logs();
      mreq(1'b0, 1'b1, 1'b0, 16'h0060, 32'h0, rc);
`ifdef CSR_ARB_TIMEOUT_EN
      for (int i = 0; i < int'(TIMEOUT) + 50 && rdv0_cyc.size() == 0; i++) tick();
      chk("t5_rdv0_cnt",  32'(rdv0_cyc.size()), 32'd1);
      chk("t5_to_lat",    qget(rdv0_cyc, 0) - qget(rd_cyc_log, 0), 32'(TIMEOUT + 1));
      chk("t5_to_data",   qget(rdv0_dat, 0), 32'hDEAD_BEEF);
      chk("t5_err_set",   32'(arb_timeout_err), 32'd1);
      clear_logs();
      fork
         mreq(1'b1, 1'b1, 1'b0, 16'h0064, 32'h0, rc);
         respond(2, 32'h1111_2222);
      join
      repeat (2) tick();
      chk("t5_good_data", qget(rdv1_dat, 0), 32'h1111_2222);
      chk("t5_err_stick", 32'(arb_timeout_err), 32'd1);
`else
      repeat (300) tick();
      chk("t5_no_rdv",   32'(rdv0_cyc.size()), 32'd0);
      chk("t5_err_zero", 32'(arb_timeout_err), 32'd0);
      pulse_dvalid(32'hCAFE_F00D);
      repeat (2) tick();
      chk("t5_rdv0_cnt",  32'(rdv0_cyc.size()), 32'd1);
      chk("t5_rdv0_data", qget(rdv0_dat, 0), 32'hCAFE_F00D);
`endif

      // Reset during RD_WAIT aborts the read; a late dvalid is ignored
      tick();
      clear_logs();
      mreq(1'b0, 1'b1, 1'b0, 16'h0070, 32'h0, rc);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_w0",   32'(bus.m0_waitrequest),   32'd1);
      chk("t6_rst_w1",   32'(bus.m1_waitrequest),   32'd1);
      chk("t6_rst_rden", 32'(bus.csr_rd_en),        32'd0);
      chk("t6_rst_addr", 32'(bus.csr_wr_rd_addr),   32'd0);
      chk("t6_rst_rdv0", 32'(bus.m0_readdatavalid), 32'd0);
      chk("t6_rst_err",  32'(arb_timeout_err),      32'd0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      pulse_dvalid(32'h1234_5678);
      repeat (3) tick();
      chk("t6_late_rdv0", 32'(rdv0_cyc.size()), 32'd0);
      chk("t6_late_rdv1", 32'(rdv1_cyc.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound
   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog got=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
